// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: the shared ALUOP encoding and the EX/MEM entry width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ex_mem_stage_pkg;

  // ALUOP encoding used by the decoder, the ALU and this stage
  localparam logic [4:0] ALUOP_ADD = 5'd0;
  localparam logic [4:0] ALUOP_SUB = 5'd1;
  localparam logic [4:0] ALUOP_AND = 5'd2;
  localparam logic [4:0] ALUOP_OR  = 5'd3;
  localparam logic [4:0] ALUOP_XOR = 5'd4;
  localparam logic [4:0] ALUOP_SLT = 5'd5;
  localparam logic [4:0] ALUOP_SLL = 5'd6;
  localparam logic [4:0] ALUOP_SRL = 5'd7;
  localparam logic [4:0] ALUOP_SRA = 5'd8;
  localparam logic [4:0] ALUOP_MUL = 5'd9;
  localparam logic [4:0] ALUOP_DIV = 5'd10;
  localparam logic [4:0] ALUOP_BEQ = 5'd11;
  localparam logic [4:0] ALUOP_BNE = 5'd12;

  // Control fields that travel with every entry: rd, reg_write, mem_read, mem_write
  localparam int EXMEM_CTRL_W = 5 + 3;

  // Packed entry width: result, store data and the control fields
  function automatic int exmem_w(input int n);
    return 2 * n + EXMEM_CTRL_W;
  endfunction

  localparam int EXMEM_W = exmem_w(32);

  // The overflow flag turns into a trap only for these opcodes
  function automatic logic ovf_qualifies(input logic [4:0] op);
    return (op == ALUOP_ADD) || (op == ALUOP_MUL) || (op == ALUOP_DIV);
  endfunction

endpackage

// File: rtl/ex_mem_stage_skid.sv
// pipe_skid_buf: a generic two-entry valid/ready skid buffer with a synchronous flush.
// Latency: one cycle from in to out when the buffer is not stalled.
// Backpressure: in_ready is registered and drops once the skid entry fills, so there is no combinational path from out_ready.
// Ports: clk, rst (sync, active-high), flush, in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld, skid_vld, main_vld_n, skid_vld_n;
  logic [W-1:0] main_dat, skid_dat, main_dat_n, skid_dat_n;
  logic         rdy_q;
  logic         accept, drain;

  assign accept    = in_valid && rdy_q;
  assign drain     = main_vld && out_ready;
  assign in_ready  = rdy_q;
  assign out_valid = main_vld;
  assign out_data  = main_dat;

  always_comb begin
    main_vld_n = main_vld;
    skid_vld_n = skid_vld;
    main_dat_n = main_dat;
    skid_dat_n = skid_dat;
    if (flush) begin
      // Flush drops both entries and ignores any same-cycle accept
      main_vld_n = 1'b0;
      skid_vld_n = 1'b0;
    end else if (!main_vld || drain) begin
      // Main is free at this edge: skid has priority so ordering is kept.
      // An accept cannot coincide with a valid skid entry because in_ready is low then.
      if (skid_vld) begin
        main_dat_n = skid_dat;
        main_vld_n = 1'b1;
        skid_vld_n = 1'b0;
      end else if (accept) begin
        main_dat_n = in_data;
        main_vld_n = 1'b1;
      end else begin
        main_vld_n = 1'b0;
      end
    end else if (accept) begin
      skid_dat_n = in_data;
      skid_vld_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_dat <= '0;
      skid_dat <= '0;
      rdy_q    <= 1'b0;
    end else begin
      main_vld <= main_vld_n;
      skid_vld <= skid_vld_n;
      main_dat <= main_dat_n;
      skid_dat <= skid_dat_n;
      rdy_q    <= !skid_vld_n;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register that resolves branches and turns qualifying ALU overflow into a precise trap.
// Latency: one cycle in to out; br_taken/exc_ovf pulse in the cycle after the accept.
// Backpressure: two-entry skid buffer with a registered in_ready that drops once both entries are occupied.
// Ports: clk, rst (sync, active-high), flush, in_* (EX side, valid/ready), out_* (MEM side, valid/ready),
//        br_taken/br_target (redirect to fetch), exc_ovf/exc_pc (trap to control).
// Optional: define EX_MEM_PERF_EN to add perf_br_cnt/perf_ovf_cnt pulse counters.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_aluop,
  input  logic [N-1:0] in_alu_out,
  input  logic         in_alu_zero,
  input  logic         in_alu_overflow,
  input  logic [N-1:0] in_pc,
  input  logic [N-1:0] in_br_target,
  input  logic         in_is_branch,
  input  logic [4:0]   in_rd,
  input  logic         in_reg_write,
  input  logic         in_mem_read,
  input  logic         in_mem_write,
  input  logic [N-1:0] in_store_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [4:0]   out_rd,
  output logic         out_reg_write,
  output logic         out_mem_read,
  output logic         out_mem_write,
  output logic [N-1:0] out_store_data,
  output logic         br_taken,
  output logic [N-1:0] br_target,
  output logic         exc_ovf,
  output logic [N-1:0] exc_pc
`ifdef EX_MEM_PERF_EN
  ,
  output logic [31:0]  perf_br_cnt,
  output logic [31:0]  perf_ovf_cnt
`endif
);

  localparam int W = exmem_w(N);

  logic         accept;
  logic         trap, squash;
  logic         fire_br, fire_ovf;
  logic [W-1:0] in_entry, out_entry;

  assign accept = in_valid && in_ready;
  assign trap   = in_alu_overflow && ovf_qualifies(in_aluop);
  // Trapping entries and branches still flow to MEM but must not touch architectural state
  assign squash = trap || in_is_branch;

  assign in_entry = {in_alu_out, in_store_data, in_rd,
                     in_reg_write && !squash,
                     in_mem_read  && !squash,
                     in_mem_write && !squash};

  pipe_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  assign {out_result, out_store_data, out_rd,
          out_reg_write, out_mem_read, out_mem_write} = out_entry;

  // Entries accepted in a flush cycle are discarded, so they raise no pulse
  assign fire_br  = accept && !flush && in_is_branch && in_alu_zero;
  assign fire_ovf = accept && !flush && trap;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken  <= 1'b0;
      br_target <= '0;
      exc_ovf   <= 1'b0;
      exc_pc    <= '0;
    end else begin
      br_taken <= fire_br;
      exc_ovf  <= fire_ovf;
      if (fire_br)  br_target <= in_br_target;
      if (fire_ovf) exc_pc    <= in_pc;
    end
  end

`ifdef EX_MEM_PERF_EN
  // Count the pulses themselves; flush leaves the counts alone
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_cnt  <= '0;
      perf_ovf_cnt <= '0;
    end else begin
      if (br_taken) perf_br_cnt  <= perf_br_cnt + 32'd1;
      if (exc_ovf)  perf_ovf_cnt <= perf_ovf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed bench for ex_mem_stage with immediate-assertion checks.
// Latency: n/a.
// Backpressure: drives out_ready directly to stall and release the stage.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready;
  logic [4:0]   in_aluop;
  logic [N-1:0] in_alu_out, in_pc, in_br_target, in_store_data;
  logic         in_alu_zero, in_alu_overflow, in_is_branch;
  logic [4:0]   in_rd;
  logic         in_reg_write, in_mem_read, in_mem_write;
  logic         out_valid, out_ready;
  logic [N-1:0] out_result, out_store_data;
  logic [4:0]   out_rd;
  logic         out_reg_write, out_mem_read, out_mem_write;
  logic         br_taken, exc_ovf;
  logic [N-1:0] br_target, exc_pc;
`ifdef EX_MEM_PERF_EN
  logic [31:0]  perf_br_cnt, perf_ovf_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.N(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
    .in_alu_out(in_alu_out), .in_alu_zero(in_alu_zero), .in_alu_overflow(in_alu_overflow),
    .in_pc(in_pc), .in_br_target(in_br_target), .in_is_branch(in_is_branch),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .br_taken(br_taken), .br_target(br_target), .exc_ovf(exc_ovf), .exc_pc(exc_pc)
`ifdef EX_MEM_PERF_EN
    , .perf_br_cnt(perf_br_cnt), .perf_ovf_cnt(perf_ovf_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    in_valid        = 1'b0;
    in_aluop        = ALUOP_ADD;
    in_alu_out      = '0;
    in_alu_zero     = 1'b0;
    in_alu_overflow = 1'b0;
    in_pc           = '0;
    in_br_target    = '0;
    in_is_branch    = 1'b0;
    in_rd           = '0;
    in_reg_write    = 1'b0;
    in_mem_read     = 1'b0;
    in_mem_write    = 1'b0;
    in_store_data   = '0;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [31:0] res, input logic ovf,
                        input logic zero, input logic br, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic rw);
    in_valid        = 1'b1;
    in_aluop        = op;
    in_alu_out      = res;
    in_alu_zero     = zero;
    in_alu_overflow = ovf;
    in_pc           = pc;
    in_br_target    = tgt;
    in_is_branch    = br;
    in_rd           = res[4:0];
    in_reg_write    = rw;
    in_mem_read     = 1'b0;
    in_mem_write    = 1'b0;
    in_store_data   = ~res;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    step(); step();

    // Reset state while rst is held
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_br_taken",  32'(br_taken),  32'd0);
    chk("rst_exc_ovf",   32'(exc_ovf),   32'd0);
    chk("rst_result",    out_result,     32'd0);

    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Stream: four back-to-back ADDs, one-cycle latency
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_op(ALUOP_ADD, 32'(i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      step();
      chk("stream_valid",  32'(out_valid),     32'd1);
      chk("stream_result", out_result,         32'(i));
      chk("stream_rw",     32'(out_reg_write), 32'd1);
    end
    chk("stream_store", out_store_data, 32'hFFFF_FFFB);
    chk("stream_rd",    32'(out_rd),    32'd4);
    idle();
    step();
    chk("stream_empty", 32'(out_valid), 32'd0);

    // Backpressure: A into main, B into skid, C held upstream
    out_ready = 1'b0;
    set_op(ALUOP_ADD, 32'hA, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("bp_a_result", out_result,       32'hA);
    chk("bp_a_ready",  32'(in_ready),    32'd1);
    set_op(ALUOP_ADD, 32'hB, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("bp_b_ready",  32'(in_ready),    32'd0);
    chk("bp_b_result", out_result,       32'hA);
    set_op(ALUOP_ADD, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("bp_hold_result", out_result,    32'hA);
    chk("bp_hold_ready",  32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_drain_b",       out_result,    32'hB);
    chk("bp_drain_b_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_drain_c",       out_result,     32'hC);
    chk("bp_drain_c_valid", 32'(out_valid), 32'd1);
    idle();
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Branch taken, then branch not taken
    set_op(ALUOP_BEQ, 32'h0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h40, 1'b1);
    step();
    chk("br_taken",  32'(br_taken),      32'd1);
    chk("br_target", br_target,          32'h40);
    chk("br_no_rw",  32'(out_reg_write), 32'd0);
    chk("br_valid",  32'(out_valid),     32'd1);
    idle();
    step();
    chk("br_one_cycle", 32'(br_taken), 32'd0);
    set_op(ALUOP_BNE, 32'h1, 1'b0, 1'b0, 1'b1, 32'h24, 32'h80, 1'b0);
    step();
    chk("br_not_taken", 32'(br_taken),  32'd0);
    chk("br_nt_valid",  32'(out_valid), 32'd1);
    idle();
    step();

    // Overflow on ADD traps; overflow on SUB is ignored
    set_op(ALUOP_ADD, 32'h7, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
    in_mem_write = 1'b1;
    step();
    chk("ovf_pulse",  32'(exc_ovf),       32'd1);
    chk("ovf_pc",     exc_pc,             32'h100);
    chk("ovf_no_rw",  32'(out_reg_write), 32'd0);
    chk("ovf_no_mw",  32'(out_mem_write), 32'd0);
    chk("ovf_valid",  32'(out_valid),     32'd1);
    idle();
    step();
    chk("ovf_one_cycle", 32'(exc_ovf), 32'd0);
    set_op(ALUOP_SUB, 32'h9, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 1'b1);
    step();
    chk("sub_no_trap", 32'(exc_ovf),       32'd0);
    chk("sub_rw",      32'(out_reg_write), 32'd1);
    idle();
    step();

    // Flush with both entries full and a taken branch offered
    out_ready = 1'b0;
    set_op(ALUOP_ADD, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    set_op(ALUOP_ADD, 32'h22, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    chk("fl_full_ready", 32'(in_ready), 32'd0);
    set_op(ALUOP_BEQ, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready),  32'd1);
    chk("fl_no_br", 32'(br_taken),  32'd0);

    // Flush with one entry held and a real accept of a taken branch
    set_op(ALUOP_ADD, 32'h33, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    set_op(ALUOP_BEQ, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h90, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    chk("fl_acc_valid", 32'(out_valid), 32'd0);
    chk("fl_acc_no_br", 32'(br_taken),  32'd0);
    chk("fl_acc_ready", 32'(in_ready),  32'd1);

    // Reset in the middle of a stall with a trap pulse pending
    set_op(ALUOP_ADD, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step();
    set_op(ALUOP_MUL, 32'h66, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 1'b1);
    step();
    idle();
    chk("mid_ovf_pulse", 32'(exc_ovf), 32'd1);
    chk("mid_full",      32'(in_ready), 32'd0);
`ifdef EX_MEM_PERF_EN
    chk("perf_br_pre",  perf_br_cnt,  32'd1);
    chk("perf_ovf_pre", perf_ovf_cnt, 32'd1);
`endif
    rst = 1'b1;
    step();
    chk("mrst_valid",  32'(out_valid),     32'd0);
    chk("mrst_result", out_result,         32'd0);
    chk("mrst_store",  out_store_data,     32'd0);
    chk("mrst_rw",     32'(out_reg_write), 32'd0);
    chk("mrst_exc",    32'(exc_ovf),       32'd0);
    chk("mrst_exc_pc", exc_pc,             32'd0);
    chk("mrst_br_tgt", br_target,          32'd0);
    chk("mrst_ready",  32'(in_ready),      32'd0);
`ifdef EX_MEM_PERF_EN
    chk("perf_br_rst",  perf_br_cnt,  32'd0);
    chk("perf_ovf_rst", perf_ovf_cnt, 32'd0);
`endif
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mrst_ready_after", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
